// File: rtl/alu_cmp_monitor_if.sv
// Wishbone slave bundle between the user project wrapper and alu_cmp_monitor.
interface alu_cmp_monitor_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/alu_cmp_monitor.sv
// Watches the two alu_xor_4 result lanes and their compare flags, counts samples and
// mismatches, latches the first failing vector and reports it over Wishbone.
//
// state   | meaning
// IDLE    | not sampling, counters held
// RUN     | every cycle counts the stage-2 vector
// HALTED  | stopped on a mismatch, waits for CLR or EN=0
module alu_cmp_monitor #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   alu_cmp_monitor_if.slave    wbs,
   input  logic [3:0]          alu_out1,
   input  logic [3:0]          alu_out2,
   input  logic                carry1,
   input  logic                carry2,
   input  logic [3:0]          cmp_x,
   input  logic                cmp_y,
   output logic                irq_o,
   output logic                halted_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam int          VEC_W   = 15;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic               en_q, en_d;
   logic               irq_en_q, irq_en_d;
   logic               stop_q, stop_d;
   logic [VEC_W-1:0]   s1_vec_q, s1_vec_d;
   logic [VEC_W-1:0]   s2_vec_q, s2_vec_d;
   logic               s2_mis_q, s2_mis_d;
   logic               s2_flt_q, s2_flt_d;
   logic [CNT_W-1:0]   samples_q, samples_d;
   logic [CNT_W-1:0]   mism_q, mism_d;
   logic [VEC_W-1:0]   first_q, first_d;
   logic [CNT_W-1:0]   first_idx_q, first_idx_d;
   logic               mstky_q, mstky_d;
   logic               fstky_q, fstky_d;
   logic               sat_q, sat_d;
   logic               irq_q, irq_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;

   logic               fire;
   logic               hit;
   logic [7:0]         off;
   logic               ctrl_wr;
   logic               clr;
   logic               sample;
   logic [31:0]        rd_data;
   logic               unused_bits;

   assign unused_bits = ^{wbs.wbs_dat_i[31:4], wbs.wbs_sel_i[3:1]};

   assign fire    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
   assign hit     = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign off     = wbs.wbs_adr_i[7:0];
   assign ctrl_wr = fire & wbs.wbs_we_i & hit & (off == 8'h00) & wbs.wbs_sel_i[0];
   assign clr     = ctrl_wr & wbs.wbs_dat_i[1];
   assign sample  = (state_q == ST_RUN) & ~clr;

   always_comb begin
      rd_data = '0;
      case (off)
         8'h00:   rd_data[3:0]       = {stop_q, irq_en_q, 1'b0, en_q};
         8'h04:   rd_data[4:0]       = {sat_q, fstky_q, mstky_q, state_q};
         8'h08:   rd_data[CNT_W-1:0] = samples_q;
         8'h0C:   rd_data[CNT_W-1:0] = mism_q;
         8'h10:   rd_data[VEC_W-1:0] = first_q;
         8'h14:   rd_data[CNT_W-1:0] = first_idx_q;
         default: rd_data = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      irq_en_d    = irq_en_q;
      stop_d      = stop_q;
      samples_d   = samples_q;
      mism_d      = mism_q;
      first_d     = first_q;
      first_idx_d = first_idx_q;
      mstky_d     = mstky_q;
      fstky_d     = fstky_q;

      // vector layout: {carry2, carry1, out2, out1, x, y}
      s1_vec_d = {carry2, carry1, alu_out2, alu_out1, cmp_x, cmp_y};
      s2_vec_d = s1_vec_q;
      s2_mis_d = |s1_vec_q[4:0];
      s2_flt_d = (s1_vec_q[4:1] != (s1_vec_q[8:5] ^ s1_vec_q[12:9])) |
                 (s1_vec_q[0] != (s1_vec_q[13] ^ s1_vec_q[14]));

      ack_d = fire;
      dat_d = (fire & ~wbs.wbs_we_i & hit) ? rd_data : 32'h0;

      if (ctrl_wr) begin
         en_d     = wbs.wbs_dat_i[0];
         irq_en_d = wbs.wbs_dat_i[2];
         stop_d   = wbs.wbs_dat_i[3];
      end

      if (clr) begin
         samples_d   = '0;
         mism_d      = '0;
         first_d     = '0;
         first_idx_d = '0;
         mstky_d     = 1'b0;
         fstky_d     = 1'b0;
      end else if (sample) begin
         if (samples_q != CNT_MAX) samples_d = samples_q + 1'b1;
         if (s2_mis_q) begin
            if (mism_q != CNT_MAX) mism_d = mism_q + 1'b1;
            mstky_d = 1'b1;
            if (!mstky_q) begin
               first_d     = s2_vec_q;
               first_idx_d = samples_q;
            end
         end
         if (s2_flt_q) fstky_d = 1'b1;
      end

      // counters only move by +1 or clear, so "reached all-ones" marks saturation
      sat_d = (sat_q & ~clr) | (samples_d == CNT_MAX) | (mism_d == CNT_MAX);
      irq_d = irq_en_d & (mstky_d | fstky_d);

      case (state_q)
         ST_IDLE: begin
            if (en_d) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en_d)                           state_d = ST_IDLE;
            else if (sample & s2_mis_q & stop_d) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (clr)       state_d = en_d ? ST_RUN : ST_IDLE;
            else if (!en_d) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= ST_IDLE;
         en_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         stop_q      <= 1'b0;
         s1_vec_q    <= '0;
         s2_vec_q    <= '0;
         s2_mis_q    <= 1'b0;
         s2_flt_q    <= 1'b0;
         samples_q   <= '0;
         mism_q      <= '0;
         first_q     <= '0;
         first_idx_q <= '0;
         mstky_q     <= 1'b0;
         fstky_q     <= 1'b0;
         sat_q       <= 1'b0;
         irq_q       <= 1'b0;
         ack_q       <= 1'b0;
         dat_q       <= '0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         irq_en_q    <= irq_en_d;
         stop_q      <= stop_d;
         s1_vec_q    <= s1_vec_d;
         s2_vec_q    <= s2_vec_d;
         s2_mis_q    <= s2_mis_d;
         s2_flt_q    <= s2_flt_d;
         samples_q   <= samples_d;
         mism_q      <= mism_d;
         first_q     <= first_d;
         first_idx_q <= first_idx_d;
         mstky_q     <= mstky_d;
         fstky_q     <= fstky_d;
         sat_q       <= sat_d;
         irq_q       <= irq_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign irq_o         = irq_q;
   assign halted_o      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_alu_cmp_monitor.sv
// Randomised bench for alu_cmp_monitor against a cycle-level reference model of the
// register map, compare rules and sequencing; narrow counters to reach saturation.
module tb_alu_cmp_monitor;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          CNT_W = 5;
   localparam int          MAXC  = (1 << CNT_W) - 1;

   logic       clk_sys;
   logic       rst_b;
   logic [3:0] alu_out1, alu_out2, cmp_x;
   logic       carry1, carry2, cmp_y;
   logic       irq_o, halted_o;

   alu_cmp_monitor_if bus ();

   alu_cmp_monitor #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
      .wb_clk_i (clk_sys),
      .wb_rst_ni(rst_b),
      .wbs      (bus),
      .alu_out1 (alu_out1),
      .alu_out2 (alu_out2),
      .carry1   (carry1),
      .carry2   (carry2),
      .cmp_x    (cmp_x),
      .cmp_y    (cmp_y),
      .irq_o    (irq_o),
      .halted_o (halted_o)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   int m_state, m_samp, m_mism, m_first, m_fidx;
   bit m_en, m_irqen, m_stop, m_mst, m_fst, m_sat, m_irq, m_ack;
   int m_dat;
   int p1, p2;
   int cur_vec;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_samp = 0; m_mism = 0; m_first = 0; m_fidx = 0;
      m_en = 0; m_irqen = 0; m_stop = 0; m_mst = 0; m_fst = 0; m_sat = 0;
      m_irq = 0; m_ack = 0; m_dat = 0; p1 = 0; p2 = 0;
   endfunction

   function automatic int model_read(int adr);
      if ((adr >>> 8) != (BASE >>> 8)) return 0;
      case (adr & 255)
         'h00: return int'(m_en) | (int'(m_irqen) << 2) | (int'(m_stop) << 3);
         'h04: return m_state | (int'(m_mst) << 2) | (int'(m_fst) << 3) | (int'(m_sat) << 4);
         'h08: return m_samp;
         'h0C: return m_mism;
         'h10: return m_first;
         'h14: return m_fidx;
         default: return 0;
      endcase
   endfunction

   // one rising edge of the reference: bus transfer, sample bookkeeping, sequencing
   function automatic void model_edge();
      bit fire, clr, counted, mis, flt;
      int rd, old, v, y, x, o1, o2, c1, c2;
      fire = bus.wbs_stb_i && bus.wbs_cyc_i && !m_ack;
      rd   = (fire && !bus.wbs_we_i) ? model_read(int'(bus.wbs_adr_i)) : 0;
      clr  = 0;
      if (fire && bus.wbs_we_i && bus.wbs_adr_i == BASE && bus.wbs_sel_i[0]) begin
         m_en    = bus.wbs_dat_i[0];
         m_irqen = bus.wbs_dat_i[2];
         m_stop  = bus.wbs_dat_i[3];
         clr     = bus.wbs_dat_i[1];
      end
      v  = p2;
      y  = v & 1;          x  = (v >> 1) & 15;
      o1 = (v >> 5) & 15;  o2 = (v >> 9) & 15;
      c1 = (v >> 13) & 1;  c2 = (v >> 14) & 1;
      mis = (x != 0) || (y != 0);
      flt = (x != (o1 ^ o2)) || (y != (c1 ^ c2));
      old = m_state;
      counted = (old == 1) && !clr;
      if (clr) begin
         m_samp = 0; m_mism = 0; m_first = 0; m_fidx = 0;
         m_mst = 0; m_fst = 0; m_sat = 0;
      end else if (counted) begin
         if (mis && !m_mst) begin
            m_first = v;
            m_fidx  = m_samp;
         end
         if (m_samp < MAXC) m_samp++;
         if (mis) begin
            if (m_mism < MAXC) m_mism++;
            m_mst = 1;
         end
         if (flt) m_fst = 1;
      end
      if (m_samp == MAXC || m_mism == MAXC) m_sat = 1;
      case (old)
         0: if (m_en) m_state = 1;
         1: if (!m_en) m_state = 0;
            else if (counted && mis && m_stop) m_state = 2;
         default: if (clr) m_state = m_en ? 1 : 0;
                  else if (!m_en) m_state = 0;
      endcase
      m_irq = m_irqen && (m_mst || m_fst);
      m_ack = fire;
      m_dat = rd;
      p2 = p1;
      p1 = cur_vec;
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      if (rst_b) model_edge();
      #1;
      chk("ack",    {31'b0, bus.wbs_ack_o}, {31'b0, m_ack});
      chk("dat",    bus.wbs_dat_o, m_dat);
      chk("irq",    {31'b0, irq_o}, {31'b0, m_irq});
      chk("halted", {31'b0, halted_o}, {31'b0, (m_state == 2)});
      @(negedge clk_sys);
   endtask

   task automatic drive(int o1, int o2, int c1, int c2, int x, int y);
      alu_out1 = 4'(o1); alu_out2 = 4'(o2); carry1 = 1'(c1); carry2 = 1'(c2);
      cmp_x = 4'(x); cmp_y = 1'(y);
      cur_vec = (c2 << 14) | (c1 << 13) | (o2 << 9) | (o1 << 5) | (x << 1) | y;
   endtask

   task automatic drive_rand();
      int r, o1, o2, c1, c2;
      r  = $urandom_range(99);
      o1 = $urandom_range(15);
      c1 = $urandom_range(1);
      if (r < 65) drive(o1, o1, c1, c1, 0, 0);
      else if (r < 82) begin
         o2 = $urandom_range(15); c2 = $urandom_range(1);
         drive(o1, o2, c1, c2, o1 ^ o2, c1 ^ c2);
      end else
         drive(o1, $urandom_range(15), c1, $urandom_range(1), $urandom_range(15), $urandom_range(1));
   endtask

   task automatic bus_req(bit we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel);
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
   endtask

   task automatic bus_idle();
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;   bus.wbs_sel_i = '0;
   endtask

   task automatic wb_wr(int off, int dat);
      bus_req(1'b1, BASE + off, dat, 4'hF); tick(); bus_idle(); tick();
   endtask

   task automatic wb_rd(int off);
      bus_req(1'b0, BASE + off, 32'h0, 4'hF); tick(); bus_idle(); tick();
   endtask

   task automatic read_all();
      for (int i = 0; i < 6; i++) wb_rd(i * 4);
      wb_rd('h40);
   endtask

   initial begin
      int hold;
      int offs[8] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h40, 'hFC};
      rst_b = 1'b0;
      bus_idle();
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (3) tick();
      rst_b = 1'b1;
      tick();
      read_all();

      // clean equal run, then a single mismatch with IRQ enabled
      wb_wr('h00, 'h5);
      repeat (10) begin drive(5, 5, 0, 0, 0, 0); tick(); end
      read_all();
      wb_wr('h00, 'h7);
      repeat (3) begin drive(9, 9, 1, 1, 0, 0); tick(); end
      drive(3, 1, 1, 0, 2, 1); tick();
      drive(9, 9, 0, 0, 0, 0);
      repeat (4) tick();
      read_all();

      // stop-on-fail, then CLR back to RUN
      wb_wr('h00, 'hF);
      repeat (5) begin drive(2, 2, 0, 0, 0, 0); tick(); end
      drive(4, 6, 0, 0, 2, 0); tick();
      drive(2, 2, 0, 0, 0, 0);
      repeat (6) tick();
      read_all();
      wb_wr('h00, 'hB);
      repeat (2) tick();
      read_all();

      // flag fault: x set while lanes agree; write to RO offset is ignored
      wb_wr('h00, 'h7);
      drive(6, 6, 0, 0, 1, 0); tick();
      drive(6, 6, 0, 0, 0, 0);
      repeat (4) tick();
      wb_wr('h08, 'h1234);
      read_all();

      // saturation with the narrow counters
      wb_wr('h00, 'h3);
      repeat (40) tick();
      read_all();

      // randomised traffic
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         drive_rand();
         if (hold > 0) hold--;
         else begin
            bus_idle();
            if ($urandom_range(99) < 12) begin
               int off, d;
               logic [31:0] base;
               logic [3:0]  sel;
               base = ($urandom_range(19) == 0) ? BASE + 32'h100 : BASE;
               hold = $urandom_range(2);
               if ($urandom_range(2) == 0) begin
                  d = (($urandom_range(7) != 0) ? 1 : 0) | (($urandom_range(11) == 0) ? 2 : 0) |
                      ($urandom_range(1) << 2) | (($urandom_range(2) == 0) ? 8 : 0) |
                      (int'($urandom_range(15)) << 4);
                  sel = 4'($urandom_range(15)) | (($urandom_range(3) != 0) ? 4'h1 : 4'h0);
                  bus_req(1'b1, base, d, sel);
               end else begin
                  off = offs[$urandom_range(7)];
                  bus_req($urandom_range(3) == 0, base + off, $urandom, 4'hF);
               end
            end
         end
         tick();
      end
      bus_idle();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      read_all();

      // reset mid-transfer: ack must drop immediately
      wb_wr('h00, 'h5);
      drive(1, 2, 0, 0, 3, 0); tick();
      repeat (3) tick();
      bus_req(1'b0, BASE + 'h08, 32'h0, 4'hF);
      tick();
      rst_b = 1'b0;
      #1;
      model_reset();
      chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
      chk("rst_dat", bus.wbs_dat_o, 32'h0);
      chk("rst_irq", {31'b0, irq_o}, 32'h0);
      chk("rst_halted", {31'b0, halted_o}, 32'h0);
      bus_idle();
      @(negedge clk_sys);
      tick();
      rst_b = 1'b1;
      tick();
      read_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
